fighter_input_ctrl: RTL

Per-player input conditioning stage feeding the player movement block. Synchronizes and debounces four raw push-buttons, buffers jump presses so a press shortly before landing still fires, and runs a frame-stepped attack state machine (startup / active / recovery) that locks out walking while an attack plays. Outputs are the movement block's `move_left`, `move_right`, `jump` and `move_enable` inputs, plus attack status for the hit-detection logic.

---
 rtl/fighter_input_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fighter_input_ctrl.sv
// Per-player input conditioning: button sync/debounce, jump press buffering and a
// frame-stepped attack state machine that gates walking and jumping while it plays.
module fighter_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned JUMP_BUF_FRAMES = 4,
  parameter int unsigned ATK_STARTUP     = 3,
  parameter int unsigned ATK_ACTIVE      = 4,
  parameter int unsigned ATK_RECOVERY    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       btn_attack,
  input  logic       jump_active,
  input  logic       hit_stun,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       move_enable,
  output logic [1:0] attack_state,
  output logic       attack_hit
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned FMAX = (ATK_STARTUP > ATK_ACTIVE)
                                 ? ((ATK_STARTUP > ATK_RECOVERY) ? ATK_STARTUP : ATK_RECOVERY)
                                 : ((ATK_ACTIVE > ATK_RECOVERY) ? ATK_ACTIVE : ATK_RECOVERY);
  localparam int unsigned FCW  = $clog2(FMAX + 1);
  localparam int unsigned JBW  = 4;
  localparam int unsigned BL   = 0;
  localparam int unsigned BR   = 1;
  localparam int unsigned BJ   = 2;
  localparam int unsigned BA   = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_RECOVERY = 2'd3
  } atk_state_e;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DCW-1:0]  dcnt_q [NBTN];

  atk_state_e      state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [JBW-1:0]  jbuf_q, jbuf_d;
  logic            areq_q, areq_d;
  logic            move_left_q, move_right_q, attack_hit_q;
  logic            jump_rise, atk_rise, jump_c;

  assign btn_raw = {btn_attack, btn_jump, btn_right, btn_left};

  // Synchronize, then flip the debounced level only after a sustained mismatch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NBTN; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= ~deb_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DCW'(1);
        end
      end
    end
  end

  assign jump_rise = deb_q[BJ] & ~deb_prev_q[BJ];
  assign atk_rise  = deb_q[BA] & ~deb_prev_q[BA];
  assign jump_c    = (jbuf_q != '0) & ~jump_active & (state_q == ST_IDLE) & ~hit_stun;

  // Attack FSM, attack request flag and jump buffer next-state
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    areq_d  = areq_q;
    jbuf_d  = jbuf_q;

    if (atk_rise && (state_q == ST_IDLE)) areq_d = 1'b1;

    if (SCEN) begin
      if (hit_stun && (state_q != ST_IDLE)) begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
        areq_d  = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (areq_q && !jump_active && !hit_stun) begin
              state_d = ST_STARTUP;
              fcnt_d  = '0;
              areq_d  = 1'b0;
            end
          end
          ST_STARTUP: begin
            if (fcnt_q == FCW'(ATK_STARTUP - 1)) begin
              state_d = ST_ACTIVE;
              fcnt_d  = '0;
            end else fcnt_d = fcnt_q + FCW'(1);
          end
          ST_ACTIVE: begin
            if (fcnt_q == FCW'(ATK_ACTIVE - 1)) begin
              state_d = ST_RECOVERY;
              fcnt_d  = '0;
            end else fcnt_d = fcnt_q + FCW'(1);
          end
          ST_RECOVERY: begin
            if (fcnt_q == FCW'(ATK_RECOVERY - 1)) begin
              state_d = ST_IDLE;
              fcnt_d  = '0;
            end else fcnt_d = fcnt_q + FCW'(1);
          end
          default: begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end
        endcase
      end
    end

    // A fresh press reloads the buffer even if a frame tick lands in the same cycle
    if (jump_rise) begin
      jbuf_d = JBW'(JUMP_BUF_FRAMES);
    end else if (SCEN) begin
      if (jump_c) jbuf_d = '0;
      else if (jbuf_q != '0) jbuf_d = jbuf_q - JBW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      areq_q       <= 1'b0;
      jbuf_q       <= '0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      attack_hit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      areq_q       <= areq_d;
      jbuf_q       <= jbuf_d;
      move_left_q  <= deb_q[BL] & (state_q == ST_IDLE);
      move_right_q <= deb_q[BR] & (state_q == ST_IDLE);
      attack_hit_q <= (state_d == ST_ACTIVE);
    end
  end

  assign move_left    = move_left_q;
  assign move_right   = move_right_q;
  assign jump         = jump_c;
  assign move_enable  = ~hit_stun & (state_q == ST_IDLE);
  assign attack_state = state_q;
  assign attack_hit   = attack_hit_q;

endmodule
